// File: rtl/rtc_bus_scheduler_pkg.sv
// Shared definitions for the RTC bus scheduler and its read/write sequencers.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package rtc_bus_scheduler_pkg;

  // Bus owner state, 2-bit encoding shared with anything decoding the state.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_GAP   = 2'd3
  } sched_state_t;

  // {a_d,cs,rd,wr}: all pins active-low, so idle is all ones.
  localparam logic [3:0] BUS_IDLE = 4'b1111;

  // Defaults; the sequencers size their own sweeps from the same numbers.
  localparam int unsigned DEF_REFRESH_CYCLES = 2000000;  // 20 ms at 100 MHz
  localparam int unsigned DEF_SEQ_CYCLES     = 352;      // 10-register sweep
  localparam int unsigned DEF_GAP_CYCLES     = 8;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rtc_refresh_timer.sv
// Free-running refresh timer raising a single read-pending flag per wrap.
// Latency: rd_pending is set on the clock edge at which the counter wraps.
// Backpressure: none; ticks that arrive while a read is still pending merge.
// Ports: clk, reset (async, active-high), rd_enable (gates tick capture),
//        rd_clear (read accepted by the scheduler), rd_pending (flag out).
module rtc_refresh_timer
  import rtc_bus_scheduler_pkg::*;
#(
  parameter int unsigned REFRESH_CYCLES = DEF_REFRESH_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic rd_enable,
  input  logic rd_clear,
  output logic rd_pending
);

  localparam int unsigned RW = cnt_width(REFRESH_CYCLES);
  localparam logic [RW-1:0] REFRESH_LAST = RW'(REFRESH_CYCLES - 1);

  logic [RW-1:0] refresh_cnt;
  logic          wrap;

  assign wrap = (refresh_cnt == REFRESH_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) refresh_cnt <= '0;
    else       refresh_cnt <= wrap ? '0 : refresh_cnt + 1'b1;
  end

  // Comes out of reset pending so a snapshot is taken straight away.
  // A tick coinciding with the clear wins: it is a newer request.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                  rd_pending <= 1'b1;
    else if (wrap && rd_enable) rd_pending <= 1'b1;
    else if (rd_clear)          rd_pending <= 1'b0;
  end

endmodule

// File: rtl/rtc_bus_scheduler.sv
// Arbitrates the single RTC bus between the read-sweep and write sequencers.
// Latency: wr_req at edge t -> WRITE after edge t+1; each job is SEQ+GAP cycles.
// Backpressure: requests are held as single pending flags; writes beat reads.
// Ports: clk, reset (async, active-high), rd_enable, wr_req, leer_bus/escr_bus
//        (sequencer pin drives), do_it_leer/do_it_escribir (sequencer enables),
//        a_d/cs/rd/wr (RTC pins), rd_done/wr_done (pulses), busy.
module rtc_bus_scheduler
  import rtc_bus_scheduler_pkg::*;
#(
  parameter int unsigned REFRESH_CYCLES = DEF_REFRESH_CYCLES,
  parameter int unsigned SEQ_CYCLES     = DEF_SEQ_CYCLES,
  parameter int unsigned GAP_CYCLES     = DEF_GAP_CYCLES
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rd_enable,
  input  logic       wr_req,
  input  logic [3:0] leer_bus,
  input  logic [3:0] escr_bus,
  output logic       do_it_leer,
  output logic       do_it_escribir,
  output logic       a_d,
  output logic       cs,
  output logic       rd,
  output logic       wr,
  output logic       rd_done,
  output logic       wr_done,
  output logic       busy
);

  // One counter times both the sequence window and the guard gap.
  localparam int unsigned CW = cnt_width((SEQ_CYCLES > GAP_CYCLES) ? SEQ_CYCLES : GAP_CYCLES);
  localparam logic [CW-1:0] SEQ_LAST = CW'(SEQ_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LAST = CW'(GAP_CYCLES - 1);

  sched_state_t  state, state_nxt;
  logic [CW-1:0] seq_cnt;
  logic          wr_pending;
  logic          rd_pending;
  logic          rd_clear;
  logic          wr_start;
  logic [3:0]    bus_sel;

  assign rd_clear = (state == ST_IDLE) && (state_nxt == ST_READ);
  assign wr_start = (state == ST_IDLE) && (state_nxt == ST_WRITE);

  rtc_refresh_timer #(
    .REFRESH_CYCLES(REFRESH_CYCLES)
  ) u_refresh (
    .clk       (clk),
    .reset     (reset),
    .rd_enable (rd_enable),
    .rd_clear  (rd_clear),
    .rd_pending(rd_pending)
  );

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (wr_pending)                    state_nxt = ST_WRITE;
        else if (rd_pending && rd_enable)  state_nxt = ST_READ;
      end
      ST_READ, ST_WRITE: begin
        if (seq_cnt == SEQ_LAST)           state_nxt = ST_GAP;
      end
      ST_GAP: begin
        if (seq_cnt == GAP_LAST)           state_nxt = ST_IDLE;
      end
      default:                             state_nxt = ST_IDLE;
    endcase
  end

  // Window counter restarts on every state change, so each window counts from 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                   seq_cnt <= '0;
    else if (state_nxt != state) seq_cnt <= '0;
    else if (state != ST_IDLE)   seq_cnt <= seq_cnt + 1'b1;
  end

  // A request arriving on the accepting cycle must survive the clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)         wr_pending <= 1'b0;
    else if (wr_req)   wr_pending <= 1'b1;
    else if (wr_start) wr_pending <= 1'b0;
  end

  // Done pulses land in the first GAP cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_done <= 1'b0;
      wr_done <= 1'b0;
    end else begin
      rd_done <= (state == ST_READ)  && (state_nxt == ST_GAP);
      wr_done <= (state == ST_WRITE) && (state_nxt == ST_GAP);
    end
  end

  // Outputs decoded from the state register; the mux lets only the owner through.
  always_comb begin
    do_it_leer     = (state == ST_READ);
    do_it_escribir = (state == ST_WRITE);
    busy           = (state != ST_IDLE);
    case (state)
      ST_READ:  bus_sel = leer_bus;
      ST_WRITE: bus_sel = escr_bus;
      default:  bus_sel = BUS_IDLE;
    endcase
    {a_d, cs, rd, wr} = bus_sel;
  end

endmodule

// File: tb/tb_rtc_bus_scheduler.sv
// Self-checking bench: constant vector table, directed multi-cycle scenarios,
// and randomized traffic compared every cycle against a timestamp-based model.
module tb_rtc_bus_scheduler;

  localparam int R = 1000;
  localparam int S = 20;
  localparam int G = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rd_enable = 1'b1;
  logic       wr_req = 1'b0;
  logic [3:0] leer_bus = 4'h0;
  logic [3:0] escr_bus = 4'h0;
  logic       do_it_leer, do_it_escribir, a_d, cs, rd, wr, rd_done, wr_done, busy;
  logic [3:0] pins;

  assign pins = {a_d, cs, rd, wr};

  rtc_bus_scheduler #(
    .REFRESH_CYCLES(R),
    .SEQ_CYCLES    (S),
    .GAP_CYCLES    (G)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .rd_enable     (rd_enable),
    .wr_req        (wr_req),
    .leer_bus      (leer_bus),
    .escr_bus      (escr_bus),
    .do_it_leer    (do_it_leer),
    .do_it_escribir(do_it_escribir),
    .a_d           (a_d),
    .cs            (cs),
    .rd            (rd),
    .wr            (wr),
    .rd_done       (rd_done),
    .wr_done       (wr_done),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: a job is an operation plus the edge it started on; its
  // phase follows from elapsed time alone (active < S, gap < S+G, else over).
  int m_cyc;    // edges since reset release == current cycle number
  int m_op;     // 0 none, 1 read, 2 write
  int m_start;  // edge index at which the current job began
  bit m_rdp, m_wrp;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, m_cyc);
    end
  endtask

  task automatic model_reset();
    m_cyc = 0; m_op = 0; m_start = 0; m_rdp = 1'b1; m_wrp = 1'b0;
  endtask

  task automatic model_edge();
    int  e;
    bit  bus_free;
    e = m_cyc;
    bus_free = (m_op == 0) || ((e - 1 - m_start) >= S + G);
    if (bus_free) begin
      if (m_wrp) begin
        m_op = 2; m_start = e; m_wrp = 1'b0;
      end else if (m_rdp && rd_enable) begin
        m_op = 1; m_start = e; m_rdp = 1'b0;
      end
    end
    if (wr_req) m_wrp = 1'b1;
    if ((e % R) == R - 1 && rd_enable) m_rdp = 1'b1;
    m_cyc++;
  endtask

  task automatic compare_all();
    logic       el_l, el_e, el_rd, el_wd, el_b;
    logic [3:0] el_p;
    int         el;
    el_l = 1'b0; el_e = 1'b0; el_rd = 1'b0; el_wd = 1'b0; el_b = 1'b0; el_p = 4'hF;
    if (m_op != 0) begin
      el = m_cyc - 1 - m_start;
      el_b = (el < S + G);
      if (el < S) begin
        el_l = (m_op == 1);
        el_e = (m_op == 2);
        el_p = (m_op == 1) ? leer_bus : escr_bus;
      end
      el_rd = (m_op == 1) && (el == S);
      el_wd = (m_op == 2) && (el == S);
    end
    check("m_do_it_leer", do_it_leer, el_l);
    check("m_do_it_escribir", do_it_escribir, el_e);
    check("m_rd_done", rd_done, el_rd);
    check("m_wr_done", wr_done, el_wd);
    check("m_busy", busy, el_b);
    check("m_pins", pins, el_p);
  endtask

  // One clock: model follows the edge, outputs compared at the falling edge.
  task automatic step();
    @(posedge clk);
    if (!reset) model_edge();
    @(negedge clk);
    compare_all();
  endtask

  task automatic run_until(input int c);
    while (m_cyc < c) step();
  endtask

  typedef struct {
    int         cyc;
    logic [3:0] lb;
    logic [3:0] eb;
    logic [3:0] exp_pins;
    logic       exp_leer;
  } vec_t;

  vec_t tbl [8];

  initial begin
    int ws, rs, n, d0, d1, hi, rdd;

    tbl[0] = '{1,  4'h0, 4'hF, 4'h0, 1'b1};
    tbl[1] = '{2,  4'hA, 4'h5, 4'hA, 1'b1};
    tbl[2] = '{3,  4'h5, 4'hA, 4'h5, 1'b1};
    tbl[3] = '{10, 4'h3, 4'h0, 4'h3, 1'b1};
    tbl[4] = '{20, 4'hE, 4'h1, 4'hE, 1'b1};
    tbl[5] = '{21, 4'h0, 4'h0, 4'hF, 1'b0};
    tbl[6] = '{24, 4'h2, 4'h4, 4'hF, 1'b0};
    tbl[7] = '{27, 4'h0, 4'h0, 4'hF, 1'b0};

    // Reset state
    model_reset();
    #3;
    check("rst_pins", pins, 4'hF);
    check("rst_leer", do_it_leer, 1'b0);
    check("rst_escr", do_it_escribir, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", {rd_done, wr_done}, 2'b00);
    repeat (2) @(posedge clk);
    @(negedge clk);
    compare_all();
    reset = 1'b0;

    // Snapshot right after reset, pin mux from the vector table
    for (int c = 1; c <= 30; c++) begin
      step();
      check("t1_leer", do_it_leer, (c <= S));
      check("t1_rd_done", rd_done, (c == S + 1));
      check("t1_busy", busy, (c <= S + G));
      for (int k = 0; k < 8; k++) begin
        if (tbl[k].cyc == c) begin
          leer_bus = tbl[k].lb;
          escr_bus = tbl[k].eb;
          #1;
          check("tbl_pins", pins, tbl[k].exp_pins);
          check("tbl_leer", do_it_leer, tbl[k].exp_leer);
        end
      end
    end

    // Single-cycle write on an idle bus
    run_until(100);
    wr_req = 1'b1;
    for (int c = 101; c <= 130; c++) begin
      step();
      wr_req = 1'b0;
      check("t2_escr", do_it_escribir, (c >= 102 && c <= 121));
      check("t2_wr_done", wr_done, (c == 122));
    end

    // Write request coincides with refresh wrap: write first, read after gap
    run_until(R - 1);
    wr_req = 1'b1;
    step();
    wr_req = 1'b0;
    ws = -1; rs = -1;
    repeat (60) begin
      step();
      if (do_it_escribir && ws < 0) ws = m_cyc;
      if (do_it_leer && rs < 0) rs = m_cyc;
    end
    check("t3_wr_start", ws, R + 1);
    check("t3_rd_after_wr", rs - ws, S + G + 1);

    // Request during WRITE queues a second write
    run_until(1100);
    wr_req = 1'b1;
    n = 0; d0 = 0; d1 = 0;
    while (m_cyc < 1170) begin
      step();
      wr_req = (m_cyc == 1110);
      if (wr_done) begin
        if (n == 0) d0 = m_cyc; else d1 = m_cyc;
        n++;
      end
    end
    wr_req = 1'b0;
    check("t4_done_count", n, 2);
    check("t4_first_done", d0, 1122);
    check("t4_done_spacing", d1 - d0, S + G + 1);

    // Pending read held across three wraps while disabled
    run_until(2 * R - 1);
    step();
    rd_enable = 1'b0;
    hi = 0;
    while (m_cyc < 5100) begin
      step();
      if (do_it_leer) hi++;
    end
    check("t5_no_read_disabled", hi, 0);
    rd_enable = 1'b1;
    step();
    check("t5_read_starts", do_it_leer, 1'b1);

    // Reset in the middle of a read (count 10)
    run_until(5111);
    check("t6_in_read", do_it_leer, 1'b1);
    reset = 1'b1;
    model_reset();
    #1;
    check("t6_pins_now", pins, 4'hF);
    check("t6_leer_now", do_it_leer, 1'b0);
    check("t6_busy_now", busy, 1'b0);
    rdd = 0;
    repeat (2) begin
      step();
      if (rd_done) rdd++;
    end
    check("t6_no_rd_done", rdd, 0);
    reset = 1'b0;
    step();
    check("t6_read_restart", do_it_leer, 1'b1);
    check("t6_restart_cycle", m_cyc, 1);

    // Randomized traffic against the model
    for (int i = 0; i < 6000; i++) begin
      step();
      wr_req   = ($urandom_range(0, 39) == 0);
      leer_bus = 4'($urandom_range(0, 15));
      escr_bus = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 299) == 0) rd_enable = ~rd_enable;
      if ($urandom_range(0, 2499) == 0) begin
        reset = 1'b1;
        model_reset();
        #1;
        compare_all();
        step();
        reset = 1'b0;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
